// File: rtl/mdu_pkg.sv
// Shared MDU types: sequential-multiplier FSM states and the Funct3 encodings it accepts.
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mulseq_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

endpackage

// File: rtl/mul_half.sv
// Combinational H x H unsigned multiplier, full 2H-bit product; zero latency, no flow control.
module mul_half #(
    parameter int H = 32
) (
    input  logic [H-1:0]   a,
    input  logic [H-1:0]   b,
    output logic [2*H-1:0] p
);

    assign p = (2*H)'(a) * (2*H)'(b);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Four-step sequential RISC-V MUL/MULH/MULHSU/MULHU on one half-width multiplier.
// Done rises on the 6th edge after the start cycle; StartE is ignored while Busy, Done holds until AckM.
module mul_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic            AckM,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic [2:0]      Funct3E,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    localparam int H = XLEN / 2;

    generate
        if (XLEN % 2 != 0) begin : g_xlen_even
            $error("mul_seq_ctrl: XLEN must be even");
        end
    endgenerate

    mulseq_state_t     state;
    logic [1:0]        step;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              neg;
    logic              sel_low;
    logic [2*XLEN-1:0] acc;

    logic              a_signed;
    logic              b_signed;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic              launch;

    logic [H-1:0]      a_half;
    logic [H-1:0]      b_half;
    logic [XLEN-1:0]   pp;
    logic [2*XLEN-1:0] pp_ext;
    logic [2*XLEN-1:0] pp_sh;
    logic [2*XLEN-1:0] acc_sum;
    logic [2*XLEN-1:0] acc_fix;

    assign a_signed = (Funct3E != F3_MULHU);
    assign b_signed = (Funct3E == F3_MUL) || (Funct3E == F3_MULH);
    assign sign_a   = a_signed & SrcAE[XLEN-1];
    assign sign_b   = b_signed & SrcBE[XLEN-1];
    // Two's-complement negate leaves the most negative value as its own magnitude, which is what we want unsigned.
    assign a_abs    = sign_a ? (~SrcAE + XLEN'(1)) : SrcAE;
    assign b_abs    = sign_b ? (~SrcBE + XLEN'(1)) : SrcBE;

    // Accept from IDLE, or straight out of DONE when the consumer acks in the same cycle.
    assign launch = ~FlushE & StartE & ~Funct3E[2]
                  & ((state == IDLE) | ((state == DONE) & AckM));

    // step[0] picks the A half, step[1] the B half: lo*lo, hi*lo, lo*hi, hi*hi.
    assign a_half = step[0] ? a_mag[XLEN-1:H] : a_mag[H-1:0];
    assign b_half = step[1] ? b_mag[XLEN-1:H] : b_mag[H-1:0];

    mul_half #(.H(H)) u_mul_half (
        .a (a_half),
        .b (b_half),
        .p (pp)
    );

    assign pp_ext = {{XLEN{1'b0}}, pp};

    always_comb begin
        pp_sh = pp_ext;
        case (step)
            2'd0:    pp_sh = pp_ext;
            2'd1,
            2'd2:    pp_sh = pp_ext << H;
            default: pp_sh = pp_ext << XLEN;
        endcase
    end

    assign acc_sum = acc + pp_sh;
    assign acc_fix = neg ? (~acc + (2*XLEN)'(1)) : acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            step    <= 2'd0;
            a_mag   <= '0;
            b_mag   <= '0;
            neg     <= 1'b0;
            sel_low <= 1'b0;
            acc     <= '0;
            Result  <= '0;
        end else if (FlushE) begin
            state <= IDLE;
        end else if (launch) begin
            state   <= MUL;
            step    <= 2'd0;
            a_mag   <= a_abs;
            b_mag   <= b_abs;
            neg     <= sign_a ^ sign_b;
            sel_low <= (Funct3E == F3_MUL);
            acc     <= '0;
        end else begin
            case (state)
                MUL: begin
                    acc  <= acc_sum;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    acc    <= acc_fix;
                    Result <= sel_low ? acc_fix[XLEN-1:0] : acc_fix[2*XLEN-1:XLEN];
                    state  <= DONE;
                end
                DONE: begin
                    if (AckM) begin
                        state <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state == MUL) || (state == FIX);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized scoreboard bench for mul_seq_ctrl at XLEN=32 against an arithmetic reference model.
module tb_mul_seq_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            StartE;
    logic            FlushE;
    logic            AckM;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic [2:0]      Funct3E;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Result;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    bit          done_q = 1'b0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .reset   (reset),
        .StartE  (StartE),
        .FlushE  (FlushE),
        .AckM    (AckM),
        .SrcAE   (SrcAE),
        .SrcBE   (SrcBE),
        .Funct3E (Funct3E),
        .Busy    (Busy),
        .Done    (Done),
        .Result  (Result)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Full-precision product with operands extended per signedness, then the requested half.
    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] ea;
        logic signed [65:0] eb;
        logic signed [65:0] p;
        ea = (f3 != 3'b011) ? {{34{a[31]}}, a} : {34'd0, a};
        eb = (f3 == 3'b000 || f3 == 3'b001) ? {{34{b[31]}}, b} : {34'd0, b};
        p  = ea * eb;
        return (f3 == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            done_q = 1'b0;
        end else begin
            if (Done && !done_q) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got 0x%0h want no completion", Result);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("result", Result, e);
                end
            end
            done_q = Done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        StartE  = 1'b1;
        Funct3E = f3;
        SrcAE   = a;
        SrcBE   = b;
        tick();
        StartE  = 1'b0;
        SrcAE   = $urandom;
        SrcBE   = $urandom;
        Funct3E = 3'($urandom_range(0, 3));
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!Done && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic ack();
        AckM = 1'b1;
        tick();
        AckM = 1'b0;
        check("done_clear", Done, 0);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit do_ack);
        int n;
        exp_q.push_back(exp);
        start_op(f3, a, b);
        check("busy_after_accept", Busy, 1);
        wait_done(n);
        check("latency", n, 6);
        if (do_ack) begin
            repeat ($urandom_range(0, 2)) begin
                tick();
                check("done_hold", Done, 1);
            end
            ack();
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        reset   = 1'b1;
        StartE  = 1'b0;
        FlushE  = 1'b0;
        AckM    = 1'b0;
        SrcAE   = '0;
        SrcBE   = '0;
        Funct3E = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        check("reset_result", Result, 0);
        reset = 1'b0;
        tick();

        run_op(3'b000, 32'd7, 32'd6, 32'h0000_002A, 1'b1);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        // Flush at step 2, with a competing start that must lose.
        start_op(3'b000, 32'd100, 32'd200);
        tick();
        tick();
        FlushE  = 1'b1;
        StartE  = 1'b1;
        Funct3E = 3'b000;
        tick();
        FlushE  = 1'b0;
        StartE  = 1'b0;
        check("flush_busy", Busy, 0);
        check("flush_done", Done, 0);
        repeat (8) tick();
        check("flush_idle_busy", Busy, 0);
        check("flush_result_kept", Result, 32'hFFFF_FFFF);
        run_op(3'b000, 32'd3, 32'd3, 32'h0000_0009, 1'b1);

        // Asynchronous reset between edges mid-operation.
        start_op(3'b000, 32'd5, 32'd5);
        tick();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_reset_busy", Busy, 0);
        check("async_reset_done", Done, 0);
        check("async_reset_result", Result, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Back-to-back accept out of DONE, held StartE, then a rejected funct3.
        run_op(3'b000, 32'd7, 32'd11, 32'd77, 1'b0);
        exp_q.push_back(32'h0000_000A);
        AckM    = 1'b1;
        StartE  = 1'b1;
        Funct3E = 3'b000;
        SrcAE   = 32'd2;
        SrcBE   = 32'd5;
        tick();
        AckM = 1'b0;
        check("b2b_busy", Busy, 1);
        check("b2b_done_low", Done, 0);
        wait_done(n);
        check("b2b_latency", n, 6);
        repeat (3) tick();
        check("held_start_done", Done, 1);
        check("held_start_busy", Busy, 0);
        Funct3E = 3'b100;
        AckM    = 1'b1;
        tick();
        AckM = 1'b0;
        check("f3_reject_busy", Busy, 0);
        check("f3_reject_done", Done, 0);
        repeat (3) tick();
        check("f3_reject_idle", Busy, 0);
        StartE = 1'b0;
        tick();

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            f3 = 3'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            if ($urandom_range(0, 7) == 0) begin
                start_op(f3, a, b);
                repeat ($urandom_range(0, 4)) tick();
                FlushE = 1'b1;
                tick();
                FlushE = 1'b0;
                check("rand_flush_busy", Busy, 0);
                check("rand_flush_done", Done, 0);
            end else begin
                run_op(f3, a, b, ref_mul(f3, a, b), 1'b1);
            end
        end

        repeat (5) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
